id_ex_stage_reg: RTL

// - ID/EX pipeline register. Sits directly downstream of the main control decoder in ID.
// - Latches the decoder's EX/MEM/WB control bundles plus ID datapath values each cycle.
// - Inserts bubbles on branch flush and on load-use hazards.
// - Drives o_stall back to the PC and IF/ID registers.

---
 rtl/id_ex_stage_reg.sv | 84 ++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoder control bundles and ID datapath values,
// inserting bubbles on flush and, when HAZARD_DETECT_EN is defined, on load-use hazards.
module id_ex_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [3:0]            i_ex,
  input  logic [2:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic [DATA_WIDTH-1:0] i_pc4,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [REG_ADDR-1:0]   i_rs,
  input  logic [REG_ADDR-1:0]   i_rt,
  input  logic [REG_ADDR-1:0]   i_rd,
  output logic [3:0]            o_ex,
  output logic [2:0]            o_mem,
  output logic [1:0]            o_wb,
  output logic [DATA_WIDTH-1:0] o_pc4,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [REG_ADDR-1:0]   o_rs,
  output logic [REG_ADDR-1:0]   o_rt,
  output logic [REG_ADDR-1:0]   o_rd,
  output logic                  o_valid,
  output logic                  o_stall
);

  logic haz;
  logic bubble;

`ifdef HAZARD_DETECT_EN
  // Conservative: both specifiers compared whatever the ID opcode actually reads.
  assign haz = o_valid & o_mem[2] & i_valid & (o_rt != '0) &
               ((o_rt == i_rs) | (o_rt == i_rt));
`else
  assign haz = 1'b0;
`endif

  assign o_stall = haz & ~i_flush;
  assign bubble  = i_flush | haz;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_ex      <= '0;
      o_mem     <= '0;
      o_wb      <= '0;
      o_pc4     <= '0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_imm     <= '0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_rd      <= '0;
      o_valid   <= 1'b0;
    end else begin
      // Datapath fields are don't-care in a bubble, so they load unconditionally.
      o_pc4     <= i_pc4;
      o_rs_data <= i_rs_data;
      o_rt_data <= i_rt_data;
      o_imm     <= i_imm;
      o_rs      <= i_rs;
      o_rt      <= i_rt;
      o_rd      <= i_rd;
      if (bubble || !i_valid) begin
        o_ex  <= '0;
        o_mem <= '0;
        o_wb  <= '0;
      end else begin
        o_ex  <= i_ex;
        o_mem <= i_mem;
        o_wb  <= i_wb;
      end
      o_valid <= i_valid & ~bubble;
    end
  end

endmodule
